fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage: PC register plus the IF/ID pipeline register of the 5-stage MIPS pipeline.
//  Consumes do_stall from the hazard/stall unit and branch redirects from ID.
//  Produces the IF/ID fields (rs, rt, memWrite) that the stall unit compares against ID/EX.
//  Also keeps a saturating stall-cycle counter for performance debug.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  CNT_W     16             width of stall_cycles counter
// PORTS
//  clk             in   1      clock, rising-edge
//  rst             in   1      reset, asynchronous, active-high
//  do_stall        in   1      1 = hold PC and IF/ID this cycle (load-use hazard)
//  branch_taken    in   1      1 = redirect fetch to branch_target, flush IF/ID
//  branch_target   in   32     redirect address; bits [1:0] ignored
//  imem_data       in   32     instruction at imem_addr (combinational read)
//  imem_addr       out  32     current PC, drives instruction memory
//  IF_ID_instr     out  32     registered instruction
//  IF_ID_pc4       out  32     registered PC+4 of that instruction
//  IF_ID_valid     out  1      1 = IF_ID_instr is a real instruction, 0 = bubble
//  IF_ID_rs        out  5      IF_ID_instr[25:21]; 0 when not valid
//  IF_ID_rt        out  5      IF_ID_instr[20:16]; 0 when not valid
//  IF_ID_memWrite  out  1      1 when valid and opcode == 6'b101011 (sw)
//  stall_cycles    out  CNT_W  count of cycles with do_stall=1
// BEHAVIOUR
//  - Reset (async, rst=1): pc=RESET_PC; IF_ID_instr=0; IF_ID_pc4=0; IF_ID_valid=0;
//    stall_cycles=0; all derived outputs therefore 0. Held for the whole time rst=1.
//  - imem_addr = pc, combinational; one-cycle fetch latency into IF/ID.
//  - Per rising edge, priority order:
//    1. do_stall=1: pc, IF_ID_* hold; branch_taken ignored this cycle (branch in ID
//       is re-evaluated once the stall clears).
//    2. branch_taken=1: pc <= {branch_target[31:2],2'b00}; IF_ID_instr <= 0;
//       IF_ID_pc4 <= 0; IF_ID_valid <= 0 (the wrong-path fetch is squashed).
//    3. otherwise: pc <= pc+4; IF_ID_instr <= imem_data; IF_ID_pc4 <= pc+4; IF_ID_valid <= 1.
//  - pc+4 is 32-bit modulo: 32'hFFFF_FFFC wraps to 32'h0000_0000, no flag.
//  - rs/rt/memWrite are combinational decodes of the IF/ID register, gated by IF_ID_valid.
//  - stall_cycles increments by 1 on each edge with do_stall=1; saturates at all-ones.
//  - A consecutive stall run holds indefinitely; no timeout.
//  - rst asserted mid-stall or mid-redirect: reset values win immediately; the
//    first edge after release fetches from RESET_PC (path 3 unless inputs say otherwise).
// TESTING
//  1. Reset, release, imem returns 0x8C0A0004 at addr 0 -> after 1 edge IF_ID_instr=0x8C0A0004,
//     pc4=4, valid=1, imem_addr=4.
//  2. Load-use: do_stall=1 for 1 cycle -> imem_addr and IF_ID_* unchanged for that edge,
//     stall_cycles=1; next edge resumes pc+4.
//  3. branch_taken=1, target=0x0000_0103 -> imem_addr=0x100, IF_ID_valid=0, rs=rt=0,
//     memWrite=0; next edge loads instr from 0x100.
//  4. do_stall=1 and branch_taken=1 same cycle -> hold wins, pc unchanged; then
//     branch_taken alone -> redirect taken.
//  5. IF/ID loads 0xAD280008 (sw) -> memWrite=1, rs=9, rt=8; pc at 0xFFFF_FFFC advances to 0.
//  6. CNT_W=4, 20 stall cycles -> stall_cycles=15 held; assert rst mid-stall -> all outputs 0,
//     imem_addr=RESET_PC immediately.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and a
// saturating stall-cycle counter for performance debug.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             do_stall,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic [31:0]      imem_data,
    output logic [31:0]      imem_addr,
    output logic [31:0]      IF_ID_instr,
    output logic [31:0]      IF_ID_pc4,
    output logic             IF_ID_valid,
    output logic [4:0]       IF_ID_rs,
    output logic [4:0]       IF_ID_rt,
    output logic             IF_ID_memWrite,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [5:0] OPC_SW = 6'b101011;

    logic [31:0]      pc_q,    pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc4_q,   pc4_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [31:0]      pc_plus4;

    // Modulo-2^32 increment: 0xFFFF_FFFC wraps to 0 with no flag.
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (do_stall) begin
            // A stall outranks a redirect; the branch is re-resolved in ID later.
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        end else if (branch_taken) begin
            pc_d    = branch_target & ~32'h0000_0003;
            instr_d = 32'h0;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
        end else begin
            pc_d    = pc_plus4;
            instr_d = imem_data;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Register fields the stall unit compares; forced to 0 on a bubble.
    assign imem_addr      = pc_q;
    assign IF_ID_instr    = instr_q;
    assign IF_ID_pc4      = pc4_q;
    assign IF_ID_valid    = valid_q;
    assign IF_ID_rs       = valid_q ? instr_q[25:21] : 5'd0;
    assign IF_ID_rt       = valid_q ? instr_q[20:16] : 5'd0;
    assign IF_ID_memWrite = valid_q && (instr_q[31:26] == OPC_SW);
    assign stall_cycles   = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a behavioural fetch model pushes expected
// IF/ID state per edge; each scenario task pops and compares.
module tb_fetch_stage;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        mw;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        do_stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_data, imem_addr, IF_ID_instr, IF_ID_pc4;
    logic        IF_ID_valid, IF_ID_memWrite;
    logic [4:0]  IF_ID_rs, IF_ID_rt;
    logic [15:0] stall_cycles;

    logic [31:0] imem_data4, imem_addr4, instr4, pc4_4;
    logic        valid4, mw4;
    logic [4:0]  rs4, rt4;
    logic [3:0]  stall_cycles4;

    int vectors     = 0;
    int miscompares = 0;

    obs_t sb[$];
    obs_t exp_o, got_o;

    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;
    logic [15:0] m_cnt;
    logic [3:0]  m_cnt4;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_f = 32'h8C0A_0004;
            32'hFFFF_FFFC: mem_f = 32'hAD28_0008;
            default:       mem_f = {~a[15:0], a[15:0]} ^ 32'h1234_0000;
        endcase
    endfunction

    assign imem_data  = mem_f(imem_addr);
    assign imem_data4 = mem_f(imem_addr4);

    fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .do_stall(do_stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_data(imem_data), .imem_addr(imem_addr),
        .IF_ID_instr(IF_ID_instr), .IF_ID_pc4(IF_ID_pc4), .IF_ID_valid(IF_ID_valid),
        .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .IF_ID_memWrite(IF_ID_memWrite),
        .stall_cycles(stall_cycles)
    );

    fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .do_stall(do_stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_data(imem_data4), .imem_addr(imem_addr4),
        .IF_ID_instr(instr4), .IF_ID_pc4(pc4_4), .IF_ID_valid(valid4),
        .IF_ID_rs(rs4), .IF_ID_rt(rt4), .IF_ID_memWrite(mw4),
        .stall_cycles(stall_cycles4)
    );

    function automatic obs_t model_obs();
        obs_t o;
        o.addr  = m_pc;
        o.instr = m_instr;
        o.pc4   = m_pc4;
        o.valid = m_valid;
        o.rs    = m_valid ? m_instr[25:21] : 5'd0;
        o.rt    = m_valid ? m_instr[20:16] : 5'd0;
        o.mw    = m_valid && (m_instr[31:26] == 6'b101011);
        o.cnt   = m_cnt;
        o.cnt4  = m_cnt4;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.addr  = imem_addr;
        o.instr = IF_ID_instr;
        o.pc4   = IF_ID_pc4;
        o.valid = IF_ID_valid;
        o.rs    = IF_ID_rs;
        o.rt    = IF_ID_rt;
        o.mw    = IF_ID_memWrite;
        o.cnt   = stall_cycles;
        o.cnt4  = stall_cycles4;
        return o;
    endfunction

    task automatic model_reset();
        m_pc    = 32'h0;
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
        m_cnt   = 16'h0;
        m_cnt4  = 4'h0;
    endtask

    // Drive one cycle of inputs, advance the model, queue the expected post-edge state.
    task automatic drive_cycle(input logic s, input logic b, input logic [31:0] t);
        do_stall      = s;
        branch_taken  = b;
        branch_target = t;
        if (s) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (m_cnt4 != 4'hF)    m_cnt4 = m_cnt4 + 4'd1;
        end else if (b) begin
            m_pc    = {t[31:2], 2'b00};
            m_instr = 32'h0;
            m_pc4   = 32'h0;
            m_valid = 1'b0;
        end else begin
            m_instr = mem_f(m_pc);
            m_pc4   = m_pc + 32'd4;
            m_pc    = m_pc + 32'd4;
            m_valid = 1'b1;
        end
        sb.push_back(model_obs());
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        do_stall = 1'b0;
        branch_taken = 1'b1;
        branch_target = 32'h0000_0040;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        sb.push_back(model_obs());
        exp_o = sb.pop_front();
        got_o = sample();
        vectors++;
        if (got_o !== exp_o) begin
            miscompares++;
            $display("FAIL reset_hold: got %h want %h", got_o, exp_o);
        end
        rst = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic test_fetch();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b0, 32'h0);
            exp_o = sb.pop_front();
            got_o = sample();
            vectors++;
            if (got_o !== exp_o) begin
                miscompares++;
                $display("FAIL fetch[%0d]: got %h want %h", i, got_o, exp_o);
            end
            if (i == 0) begin
                vectors++;
                if ({IF_ID_instr, IF_ID_pc4, IF_ID_valid, imem_addr} !==
                    {32'h8C0A_0004, 32'd4, 1'b1, 32'd4}) begin
                    miscompares++;
                    $display("FAIL first_fetch: got instr=%h pc4=%h v=%b addr=%h want 8c0a0004/4/1/4",
                             IF_ID_instr, IF_ID_pc4, IF_ID_valid, imem_addr);
                end
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(i == 0, 1'b0, 32'h0);
            exp_o = sb.pop_front();
            got_o = sample();
            vectors++;
            if (got_o !== exp_o) begin
                miscompares++;
                $display("FAIL stall[%0d]: got %h want %h", i, got_o, exp_o);
            end
        end
    endtask

    task automatic test_branch();
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b0, i == 0, 32'h0000_0103);
            exp_o = sb.pop_front();
            got_o = sample();
            vectors++;
            if (got_o !== exp_o) begin
                miscompares++;
                $display("FAIL branch[%0d]: got %h want %h", i, got_o, exp_o);
            end
            if (i == 0) begin
                vectors++;
                if ({imem_addr, IF_ID_valid, IF_ID_rs, IF_ID_rt, IF_ID_memWrite} !==
                    {32'h0000_0100, 1'b0, 5'd0, 5'd0, 1'b0}) begin
                    miscompares++;
                    $display("FAIL branch_redirect: got addr=%h v=%b rs=%0d rt=%0d mw=%b want 100/0/0/0/0",
                             imem_addr, IF_ID_valid, IF_ID_rs, IF_ID_rt, IF_ID_memWrite);
                end
            end
        end
    endtask

    task automatic test_stall_and_branch();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(i == 0, i < 2, 32'h0000_0208);
            exp_o = sb.pop_front();
            got_o = sample();
            vectors++;
            if (got_o !== exp_o) begin
                miscompares++;
                $display("FAIL stall_branch[%0d]: got %h want %h", i, got_o, exp_o);
            end
        end
    endtask

    task automatic test_wrap_sw();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, i == 0, 32'hFFFF_FFFF);
            exp_o = sb.pop_front();
            got_o = sample();
            vectors++;
            if (got_o !== exp_o) begin
                miscompares++;
                $display("FAIL wrap_sw[%0d]: got %h want %h", i, got_o, exp_o);
            end
            if (i == 1) begin
                vectors++;
                if ({IF_ID_instr, IF_ID_memWrite, IF_ID_rs, IF_ID_rt, IF_ID_pc4, imem_addr} !==
                    {32'hAD28_0008, 1'b1, 5'd9, 5'd8, 32'd0, 32'd0}) begin
                    miscompares++;
                    $display("FAIL sw_decode: got instr=%h mw=%b rs=%0d rt=%0d pc4=%h addr=%h want ad280008/1/9/8/0/0",
                             IF_ID_instr, IF_ID_memWrite, IF_ID_rs, IF_ID_rt, IF_ID_pc4, imem_addr);
                end
            end
        end
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b1, 1'b0, 32'h0);
            exp_o = sb.pop_front();
            got_o = sample();
            vectors++;
            if (got_o !== exp_o) begin
                miscompares++;
                $display("FAIL sat[%0d]: got %h want %h", i, got_o, exp_o);
            end
        end
        vectors++;
        if ({stall_cycles4, stall_cycles} !== {4'hF, 16'd20}) begin
            miscompares++;
            $display("FAIL sat_value: got cnt4=%0d cnt=%0d want 15/20", stall_cycles4, stall_cycles);
        end
        // Reset lands mid-cycle while the stall is still asserted.
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        sb.push_back(model_obs());
        exp_o = sb.pop_front();
        got_o = sample();
        vectors++;
        if (got_o !== exp_o) begin
            miscompares++;
            $display("FAIL reset_mid_stall: got %h want %h", got_o, exp_o);
        end
        vectors++;
        if ({imem_addr4, instr4, pc4_4, valid4, rs4, rt4, mw4} !==
            {exp_o.addr, exp_o.instr, exp_o.pc4, exp_o.valid, exp_o.rs, exp_o.rt, exp_o.mw}) begin
            miscompares++;
            $display("FAIL reset_mid_stall_cnt4: got addr=%h instr=%h pc4=%h v=%b want all 0",
                     imem_addr4, instr4, pc4_4, valid4);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_cycle(1'b0, 1'b0, 32'h0);
        exp_o = sb.pop_front();
        got_o = sample();
        vectors++;
        if (got_o !== exp_o || IF_ID_instr !== 32'h8C0A_0004) begin
            miscompares++;
            $display("FAIL post_reset_fetch: got %h want %h", got_o, exp_o);
        end
    endtask

    task automatic test_back_to_back();
        logic s, b;
        for (int i = 0; i < 40; i++) begin
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 4) == 0);
            drive_cycle(s, b, $urandom);
            exp_o = sb.pop_front();
            got_o = sample();
            vectors++;
            if (got_o !== exp_o) begin
                miscompares++;
                $display("FAIL b2b[%0d] s=%b b=%b: got %h want %h", i, s, b, got_o, exp_o);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        do_stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'h0;
        model_reset();
        test_reset();
        test_fetch();
        test_stall();
        test_branch();
        test_stall_and_branch();
        test_wrap_sw();
        test_saturation();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
